// File: rtl/mp64_mem_ctrl_pkg.sv
// Shared definitions for the mp64 memory-side sequencer: size codes, error
// data pattern, default geometry and lane helpers.
package mp64_mem_ctrl_pkg;

   localparam logic [1:0]  MEM_SZ_B = 2'd0;
   localparam logic [1:0]  MEM_SZ_H = 2'd1;
   localparam logic [1:0]  MEM_SZ_W = 2'd2;
   localparam logic [1:0]  MEM_SZ_D = 2'd3;

   localparam logic [63:0] MEM_ERR_DATA    = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam int          MEM_BRAM_AW     = 14;
   localparam int          MEM_EXT_TIMEOUT = 255;

   typedef struct packed {
      logic [63:0] addr;
      logic [63:0] wdata;
      logic        wen;
      logic [1:0]  size;
   } mem_req_t;

   // Right-justified byte-enable pattern for an access of the given size.
   function automatic logic [7:0] size_mask(input logic [1:0] size);
      case (size)
         MEM_SZ_B: return 8'h01;
         MEM_SZ_H: return 8'h03;
         MEM_SZ_W: return 8'h0F;
         default:  return 8'hFF;
      endcase
   endfunction

   function automatic logic is_misaligned(input logic [2:0] lo, input logic [1:0] size);
      case (size)
         MEM_SZ_B: return 1'b0;
         MEM_SZ_H: return lo[0];
         MEM_SZ_W: return |lo[1:0];
         default:  return |lo;
      endcase
   endfunction

endpackage

// File: rtl/mp64_mem_ctrl_if.sv
// Request/acknowledge bus between the arbiter memory port and the sequencer.
interface mp64_mem_ctrl_if;
   logic        mem_req;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic        mem_wen;
   logic [1:0]  mem_size;
   logic [63:0] mem_rdata;
   logic        mem_ack;

   modport master (
      output mem_req, mem_addr, mem_wdata, mem_wen, mem_size,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_req, mem_addr, mem_wdata, mem_wen, mem_size,
      output mem_rdata, mem_ack
   );
endinterface

// File: rtl/mp64_lane_align.sv
// Combinational byte-lane alignment: write enables and data shift, plus read
// extraction with zero-extension to the access size.
module mp64_lane_align
   import mp64_mem_ctrl_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [2:0]  offset,
   input  logic [63:0] wdata,
   input  logic [63:0] rdata_raw,
   output logic [7:0]  byte_en,
   output logic [63:0] wdata_lane,
   output logic [63:0] rdata_ext
);

   logic [7:0]  size_be;
   logic [63:0] rd_shifted;

   always_comb begin
      size_be    = size_mask(size);
      byte_en    = size_be << offset;
      wdata_lane = wdata << {offset, 3'b000};
      rd_shifted = rdata_raw >> {offset, 3'b000};
   end

   // Zero every byte above the access size after the lane has been brought down.
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_rd_lane
         assign rdata_ext[8*gi +: 8] = rd_shifted[8*gi +: 8] & {8{size_be[gi]}};
      end
   endgenerate

endmodule

// File: rtl/mp64_mem_ctrl.sv
// Memory-side sequencer: routes one request at a time to the internal BRAM
// window or to the external port, with misalignment and timeout reporting.
module mp64_mem_ctrl
   import mp64_mem_ctrl_pkg::*;
#(
   parameter int BRAM_AW     = MEM_BRAM_AW,
   parameter int EXT_TIMEOUT = MEM_EXT_TIMEOUT
) (
   input  logic               clk,
   input  logic               rst,
   mp64_mem_ctrl_if.slave     mem,
   output logic               bram_en,
   output logic [7:0]         bram_we,
   output logic [BRAM_AW-1:0] bram_addr,
   output logic [63:0]        bram_wdata,
   input  logic [63:0]        bram_rdata,
   output logic               ext_req,
   output logic [63:0]        ext_addr,
   output logic [63:0]        ext_wdata,
   output logic               ext_wen,
   output logic [1:0]         ext_size,
   input  logic [63:0]        ext_rdata,
   input  logic               ext_ack,
   output logic               err_valid,
   output logic [63:0]        err_addr,
   output logic [15:0]        err_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_BRAM_ACC,
      S_BRAM_RESP,
      S_EXT_WAIT,
      S_ERR_RESP
   } state_e;

   // The abort happens in the EXT_TIMEOUT-th wait cycle (counter starts at 0).
   localparam logic [15:0] TIMEOUT_LAST = 16'(EXT_TIMEOUT - 1);

   state_e      state_reg, state_next;
   mem_req_t    req_reg;
   logic [15:0] wait_cnt_reg;
   logic [63:0] rdata_reg;
   logic [63:0] err_addr_reg;
   logic [15:0] err_count_reg;

   logic        in_window;
   logic        misalign;
   logic        timeout_hit;
   logic        ack;
   logic        err_pulse;
   logic [63:0] resp_data;

   logic [2:0]  lane_offset;
   logic [63:0] lane_rdata_raw;
   logic [7:0]  lane_be;
   logic [63:0] lane_wdata;
   logic [63:0] lane_rdata;

   assign in_window   = (mem.mem_addr >> (BRAM_AW + 3)) == '0;
   assign misalign    = is_misaligned(mem.mem_addr[2:0], mem.mem_size);
   assign timeout_hit = (wait_cnt_reg == TIMEOUT_LAST);

   // External data is already right-justified, so it bypasses the lane shift.
   assign lane_offset    = (state_reg == S_EXT_WAIT) ? 3'd0 : req_reg.addr[2:0];
   assign lane_rdata_raw = (state_reg == S_EXT_WAIT) ? ext_rdata : bram_rdata;

   mp64_lane_align u_lane_align (
      .size      (req_reg.size),
      .offset    (lane_offset),
      .wdata     (req_reg.wdata),
      .rdata_raw (lane_rdata_raw),
      .byte_en   (lane_be),
      .wdata_lane(lane_wdata),
      .rdata_ext (lane_rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      ack        = 1'b0;
      err_pulse  = 1'b0;
      resp_data  = rdata_reg;
      bram_en    = 1'b0;
      bram_we    = 8'h00;
      ext_req    = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (mem.mem_req) begin
               if (misalign) begin
                  state_next = S_ERR_RESP;
               end else if (in_window) begin
                  state_next = S_BRAM_ACC;
               end else begin
                  state_next = S_EXT_WAIT;
               end
            end
         end
         S_BRAM_ACC: begin
            bram_en    = 1'b1;
            bram_we    = req_reg.wen ? lane_be : 8'h00;
            state_next = S_BRAM_RESP;
         end
         S_BRAM_RESP: begin
            ack        = 1'b1;
            resp_data  = req_reg.wen ? 64'd0 : lane_rdata;
            state_next = S_IDLE;
         end
         S_EXT_WAIT: begin
            ext_req = 1'b1;
            if (ext_ack) begin
               ack        = 1'b1;
               resp_data  = req_reg.wen ? 64'd0 : lane_rdata;
               state_next = S_IDLE;
            end else if (timeout_hit) begin
               ack        = 1'b1;
               err_pulse  = 1'b1;
               resp_data  = MEM_ERR_DATA;
               state_next = S_IDLE;
            end
         end
         S_ERR_RESP: begin
            ack        = 1'b1;
            err_pulse  = 1'b1;
            resp_data  = MEM_ERR_DATA;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_reg       <= '0;
         wait_cnt_reg  <= 16'd0;
         rdata_reg     <= 64'd0;
         err_addr_reg  <= 64'd0;
         err_count_reg <= 16'd0;
      end else begin
         if (state_reg == S_IDLE && mem.mem_req) begin
            req_reg.addr  <= mem.mem_addr;
            req_reg.wdata <= mem.mem_wdata;
            req_reg.wen   <= mem.mem_wen;
            req_reg.size  <= mem.mem_size;
         end
         wait_cnt_reg <= (state_reg == S_EXT_WAIT) ? wait_cnt_reg + 16'd1 : 16'd0;
         if (ack) begin
            rdata_reg <= resp_data;
         end
         if (err_pulse) begin
            err_addr_reg <= req_reg.addr;
            if (err_count_reg != 16'hFFFF) begin
               err_count_reg <= err_count_reg + 16'd1;
            end
         end
      end
   end

   // Response data is presented in the ack cycle and then held until the next ack.
   assign mem.mem_ack   = ack;
   assign mem.mem_rdata = resp_data;

   assign bram_addr  = req_reg.addr[BRAM_AW+2:3];
   assign bram_wdata = lane_wdata;

   assign ext_addr  = req_reg.addr;
   assign ext_wdata = req_reg.wdata;
   assign ext_wen   = req_reg.wen;
   assign ext_size  = req_reg.size;

   assign err_valid = err_pulse;
   assign err_addr  = err_addr_reg;
   assign err_count = err_count_reg;

endmodule

// File: doc/mp64_mem_ctrl.md
Name: mp64_mem_ctrl

Overview:
Memory-side sequencer behind the bus arbiter's memory port. It accepts one request at a time on the mem_req/mem_ack handshake. Addresses inside the internal window go to a synchronous 64-bit BRAM with byte-lane write enables. All other addresses are forwarded on an external req/ack port with a bounded timeout. It also handles sub-word lane alignment, misalignment errors and error reporting.

Parameters:
BRAM_AW, 14, BRAM word-address width (64-bit words); internal window is byte addresses 0 .. 2^(BRAM_AW+3)-1
EXT_TIMEOUT, 255, cycles in EXT_WAIT without ext_ack before abort (1..65535)

Ports:
clk  in  1  clock
rst  in  1  reset
mem_req  in  1  request level from bus; held until mem_ack
mem_addr  in  64  byte address
mem_wdata  in  64  write data, right-justified
mem_wen  in  1  1=write
mem_size  in  2  0=byte 1=half 2=word32 3=dword64
mem_rdata  out  64  read data, right-justified, zero-extended
mem_ack  out  1  one-cycle completion pulse
bram_en  out  1  BRAM access strobe
bram_we  out  8  per-byte write enables
bram_addr  out  BRAM_AW  word address
bram_wdata  out  64  lane-shifted write data
bram_rdata  in  64  BRAM read data, valid the cycle after bram_en
ext_req  out  1  external request level
ext_addr  out  64  byte address
ext_wdata  out  64  right-justified write data
ext_wen  out  1  1=write
ext_size  out  2  size code
ext_rdata  in  64  right-justified read data, valid with ext_ack
ext_ack  in  1  external completion pulse
err_valid  out  1  one-cycle pulse on misalign or timeout
err_addr  out  64  address of the last errored request
err_count  out  16  saturating error counter

Behaviour:
- Reset: one clock, clk. Reset is asynchronous and active-high, rst. While rst is high, every output is 0 and the state is IDLE. Reset during any state aborts the operation; ext_req drops immediately.
- States: IDLE, BRAM_ACC, BRAM_RESP, EXT_WAIT, ERR_RESP.
- IDLE: mem_req is sampled only here. On mem_req=1 the controller registers addr, wdata, wen and size, then selects a path:
  - misaligned (addr mod 2^size != 0) -> ERR_RESP
  - addr < 2^(BRAM_AW+3) -> BRAM_ACC; bram_en=1, bram_addr=addr[BRAM_AW+2:3]
  - otherwise -> EXT_WAIT with ext_req=1 and ext_* fields loaded
- BRAM path:
  - Write: bram_we = size mask shifted by addr[2:0]; bram_wdata = wdata << 8*addr[2:0]. Masks are 0x01/0x03/0x0F/0xFF for sizes 0..3.
  - Read: bram_we=0.
  - BRAM_ACC lasts one cycle, bram_en drops, then -> BRAM_RESP.
  - BRAM_RESP: mem_ack=1. For a read, mem_rdata = (bram_rdata >> 8*addr[2:0]) masked to size. For a write, mem_rdata=0. Then -> IDLE.
  - Accept-to-ack latency is exactly 2 cycles for reads and writes.
- EXT_WAIT:
  - ext_req and its fields are held stable. A 16-bit wait counter starts at 0 on entry and increments each cycle.
  - On ext_ack: ext_req<=0, mem_rdata<=ext_rdata masked to size (0 for writes), mem_ack=1, -> IDLE.
  - If the counter reaches EXT_TIMEOUT with no ack: ext_req<=0, mem_rdata<=64'hFFFF_FFFF_FFFF_FFFF, mem_ack=1, err pulse, -> IDLE.
  - If ext_ack arrives in the same cycle as the timeout, the ack wins.
  - ext_ack outside EXT_WAIT is ignored, including a late ack after a timeout.
- ERR_RESP: one cycle. mem_ack=1, mem_rdata=all ones, err pulse. No BRAM or external access occurs; a misaligned write does not modify memory.
- Err pulse: err_valid=1 for one cycle, err_addr<=request addr, err_count increments and saturates at 16'hFFFF.
- mem_ack always returns the FSM to IDLE. The requester drops mem_req the cycle after the ack, so no request is accepted twice. The earliest next accept is the cycle after the ack.
- mem_rdata holds its last value between acks.

Decomposition:
- Shared mp64_defs.vh gains:
  - size codes MEM_SZ_B/H/W/D
  - MEM_ERR_DATA (all ones)
  - default MEM_BRAM_AW
  - default MEM_EXT_TIMEOUT
- FSM state encodings stay local.
- One combinational sub-module, mp64_lane_align, is natural. It produces the write byte-enable mask, the write lane shift, and the read extract/zero-extend from (size, addr[2:0]). It is shared by the BRAM and external read paths.

Test Plan:
- BRAM dword write 0x1122334455667788 at addr 0x40, then dword read -> bram_we=8'hFF; mem_ack exactly 2 cycles after accept; rdata 0x1122334455667788.
- Byte write 0xAB at addr 0x45, then dword read at 0x40 -> bram_we=8'h20; rdata 0x1122AB4455667788. Half read at 0x44 -> rdata 0x0000_0000_0000_AB44.
- Half read at addr 0x41 -> no bram_en; ack 1 cycle after accept; rdata all ones; err_valid pulse; err_addr=0x41; err_count=1.
- External read at 0x8000_0000 with ext_ack after 5 cycles, ext_rdata=0xDEAD -> ext_req high for 5 cycles; mem_ack the cycle of ext_ack; rdata 0xDEAD.
- EXT_TIMEOUT=8 with no ext_ack -> ext_req drops after 8 wait cycles; ack with all ones; err pulse. A later stray ext_ack is ignored. Back-to-back BRAM read completes normally.
- rst asserted mid EXT_WAIT -> ext_req and mem_ack go 0 asynchronously. After release the controller is in IDLE and serves a new BRAM request with 2-cycle latency.
